// File: rtl/bus_cycle_sequencer.sv
// Master timing and external-bus controller for the i4004 core.
// Produces the two-phase clocks, the eight-subcycle instruction cycle
// strobes and SYNC, and decides who drives the 4-bit external data bus.
module bus_cycle_sequencer #(
    parameter int SUB_TICKS = 8,  // sysclk cycles per subcycle; even, >= 4
    parameter int CLK_W     = 2   // clk1/clk2 high width; 1..SUB_TICKS/2-1
) (
    input  logic       i_sysclk,
    input  logic       i_poc,
    input  logic       i_run_en,
    input  logic [3:0] i_ip_addr,
    input  logic       i_src_req,
    input  logic [3:0] i_sp_data,
    input  logic       i_iow_req,
    input  logic [3:0] i_acc_data,
    input  logic       i_ior_req,
    output logic       o_clk1,
    output logic       o_clk2,
    output logic       o_a12,
    output logic       o_a22,
    output logic       o_a32,
    output logic       o_m12,
    output logic       o_m22,
    output logic       o_x12,
    output logic       o_x22,
    output logic       o_x32,
    output logic       o_sync,
    output logic [3:0] o_data_out,
    output logic       o_data_dir,
    output logic       o_bus_conflict,
    output logic       o_idle
);
    localparam int TW = $clog2(SUB_TICKS);
    localparam logic [TW-1:0] C_LAST     = TW'(SUB_TICKS - 1);
    localparam logic [TW-1:0] C_CLKW     = TW'(CLK_W);
    localparam logic [TW-1:0] C_HALF     = TW'(SUB_TICKS / 2);
    localparam logic [TW-1:0] C_HALF_END = TW'(SUB_TICKS / 2 + CLK_W);

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_A1   = 4'd1,
        ST_A2   = 4'd2,
        ST_A3   = 4'd3,
        ST_M1   = 4'd4,
        ST_M2   = 4'd5,
        ST_X1   = 4'd6,
        ST_X2   = 4'd7,
        ST_X3   = 4'd8
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [TW-1:0]   r_tcnt;
    logic [TW-1:0]   w_tcnt_next;
    logic            w_wrap;
    logic            w_capture;
    logic            w_x3_exit;
    logic            w_multi_req;

    logic            r_src;
    logic            r_iow;
    logic            r_ior;
    logic            r_bus_conflict;

    logic            w_dir;
    logic [3:0]      w_dout;
    logic [7:0]      w_strobe;

    logic            r_clk1;
    logic            r_clk2;
    logic [7:0]      r_strobe;
    logic            r_sync;
    logic            r_idle;
    logic            r_data_dir;
    logic [3:0]      r_data_out;

    assign w_wrap      = (r_tcnt == C_LAST);
    assign w_capture   = (r_state == ST_M2) && w_wrap;
    assign w_x3_exit   = (r_state == ST_X3) && w_wrap;
    assign w_multi_req = (i_src_req & i_iow_req) | (i_src_req & i_ior_req) |
                         (i_iow_req & i_ior_req);

    // State and tick counter registers; poc aborts any cycle in progress.
    always_ff @(posedge i_sysclk or posedge i_poc) begin
        if (i_poc) begin
            r_state <= ST_IDLE;
            r_tcnt  <= '0;
        end else begin
            r_state <= w_state_next;
            r_tcnt  <= w_tcnt_next;
        end
    end

    // Next state: advance one subcycle on each tick wrap; run_en only matters in IDLE and at X3 wrap.
    always_comb begin
        w_state_next = r_state;
        w_tcnt_next  = '0;
        if (r_state != ST_IDLE && !w_wrap) begin
            w_tcnt_next = r_tcnt + 1'b1;
        end
        unique case (r_state)
            ST_IDLE: if (i_run_en) w_state_next = ST_A1;
            ST_A1:   if (w_wrap)   w_state_next = ST_A2;
            ST_A2:   if (w_wrap)   w_state_next = ST_A3;
            ST_A3:   if (w_wrap)   w_state_next = ST_M1;
            ST_M1:   if (w_wrap)   w_state_next = ST_M2;
            ST_M2:   if (w_wrap)   w_state_next = ST_X1;
            ST_X1:   if (w_wrap)   w_state_next = ST_X2;
            ST_X2:   if (w_wrap)   w_state_next = ST_X3;
            ST_X3:   if (w_wrap)   w_state_next = i_run_en ? ST_A1 : ST_IDLE;
            default:               w_state_next = ST_IDLE;
        endcase
    end

    // Request latch: resolve priority at the M2->X1 edge, hold through X3, flag simultaneous requests.
    always_ff @(posedge i_sysclk or posedge i_poc) begin
        if (i_poc) begin
            r_src          <= 1'b0;
            r_iow          <= 1'b0;
            r_ior          <= 1'b0;
            r_bus_conflict <= 1'b0;
        end else begin
            r_bus_conflict <= w_capture && w_multi_req;
            if (w_capture) begin
                r_src <= i_src_req;
                r_iow <= i_iow_req & ~i_src_req;
                r_ior <= i_ior_req & ~i_src_req & ~i_iow_req;
            end else if (w_x3_exit) begin
                r_src <= 1'b0;
                r_iow <= 1'b0;
                r_ior <= 1'b0;
            end
        end
    end

    // Bus owner for the subcycle being entered; the pad is released unless someone is chosen.
    always_comb begin
        w_dir  = 1'b0;
        w_dout = 4'h0;
        case (w_state_next)
            ST_A1, ST_A2, ST_A3: begin
                w_dir  = 1'b1;
                w_dout = i_ip_addr;
            end
            ST_X2: begin
                if (r_src) begin
                    w_dir  = 1'b1;
                    w_dout = i_sp_data;
                end else if (r_iow) begin
                    w_dir  = 1'b1;
                    w_dout = i_acc_data;
                end else if (r_ior) begin
                    w_dir  = 1'b0;  // bus released so the device can drive it
                end
            end
            ST_X3: begin
                if (r_src) begin
                    w_dir  = 1'b1;
                    w_dout = i_sp_data;
                end
            end
            default: begin
                w_dir  = 1'b0;
                w_dout = 4'h0;
            end
        endcase
    end

    // One-hot subcycle strobes decoded from the next state; bit 7 is A1, bit 0 is X3.
    for (genvar gi = 0; gi < 8; gi++) begin : g_strobe
        assign w_strobe[7-gi] = (w_state_next == 4'(gi + 1));
    end

    // Registered timing outputs and bus drive so every pin is glitch-free and aligned to state.
    always_ff @(posedge i_sysclk or posedge i_poc) begin
        if (i_poc) begin
            r_clk1     <= 1'b0;
            r_clk2     <= 1'b0;
            r_strobe   <= 8'h00;
            r_sync     <= 1'b0;
            r_idle     <= 1'b1;
            r_data_dir <= 1'b0;
            r_data_out <= 4'h0;
        end else begin
            r_clk1     <= (w_state_next != ST_IDLE) && (w_tcnt_next < C_CLKW);
            r_clk2     <= (w_state_next != ST_IDLE) && (w_tcnt_next >= C_HALF) &&
                          (w_tcnt_next < C_HALF_END);
            r_strobe   <= w_strobe;
            r_sync     <= (w_state_next == ST_X3);
            r_idle     <= (w_state_next == ST_IDLE);
            r_data_dir <= w_dir;
            r_data_out <= w_dir ? w_dout : 4'h0;
        end
    end

    assign o_clk1         = r_clk1;
    assign o_clk2         = r_clk2;
    assign o_a12          = r_strobe[7];
    assign o_a22          = r_strobe[6];
    assign o_a32          = r_strobe[5];
    assign o_m12          = r_strobe[4];
    assign o_m22          = r_strobe[3];
    assign o_x12          = r_strobe[2];
    assign o_x22          = r_strobe[1];
    assign o_x32          = r_strobe[0];
    assign o_sync         = r_sync;
    assign o_idle         = r_idle;
    assign o_data_dir     = r_data_dir;
    assign o_data_out     = r_data_out;
    assign o_bus_conflict = r_bus_conflict;

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Self-checking bench for bus_cycle_sequencer. The reference model tracks the
// position inside the 64-tick instruction cycle and derives all outputs from it.
module tb_bus_cycle_sequencer;
    localparam int ST    = 8;
    localparam int CW    = 2;
    localparam int CYCLE = 8 * ST;

    logic       sysclk = 1'b0;
    logic       poc, run_en, src_req, iow_req, ior_req;
    logic [3:0] ip_addr, sp_data, acc_data;
    logic       clk1, clk2, a12, a22, a32, m12, m22, x12, x22, x32;
    logic       sync, data_dir, bus_conflict, idle;
    logic [3:0] data_out;

    int checks = 0;
    int failures = 0;

    // model state
    bit          m_idle;
    int          m_pos;
    bit          m_src, m_iow;
    logic [17:0] exp_vec;

    bus_cycle_sequencer #(.SUB_TICKS(ST), .CLK_W(CW)) dut (
        .i_sysclk(sysclk), .i_poc(poc), .i_run_en(run_en), .i_ip_addr(ip_addr),
        .i_src_req(src_req), .i_sp_data(sp_data), .i_iow_req(iow_req),
        .i_acc_data(acc_data), .i_ior_req(ior_req),
        .o_clk1(clk1), .o_clk2(clk2), .o_a12(a12), .o_a22(a22), .o_a32(a32),
        .o_m12(m12), .o_m22(m22), .o_x12(x12), .o_x22(x22), .o_x32(x32),
        .o_sync(sync), .o_data_out(data_out), .o_data_dir(data_dir),
        .o_bus_conflict(bus_conflict), .o_idle(idle)
    );

    always #5 sysclk = ~sysclk;

    function automatic logic [17:0] dut_vec();
        return {clk1, clk2, a12, a22, a32, m12, m22, x12, x22, x32,
                sync, idle, data_dir, data_out, bus_conflict};
    endfunction

    function automatic logic [17:0] model_expect(bit conf);
        int         sub, tk;
        bit         c1, c2, dir;
        logic [7:0] strb;
        logic [3:0] d;
        if (m_idle) return 18'b0_0_00000000_0_1_0_0000_0;
        sub  = m_pos / ST;
        tk   = m_pos % ST;
        c1   = (tk < CW);
        c2   = (tk >= ST / 2) && (tk < ST / 2 + CW);
        strb = 8'h80 >> sub;
        dir  = 1'b0;
        d    = 4'h0;
        if (sub < 3) begin
            dir = 1'b1; d = ip_addr;
        end else if (sub == 6 && m_src) begin
            dir = 1'b1; d = sp_data;
        end else if (sub == 6 && m_iow) begin
            dir = 1'b1; d = acc_data;
        end else if (sub == 7 && m_src) begin
            dir = 1'b1; d = sp_data;
        end
        return {c1, c2, strb, (sub == 7), 1'b0, dir, d, conf};
    endfunction

    task automatic model_reset();
        m_idle  = 1'b1;
        m_pos   = 0;
        m_src   = 1'b0;
        m_iow   = 1'b0;
        exp_vec = model_expect(1'b0);
    endtask

    // Advance the model by one sysclk using the inputs present at that edge.
    task automatic model_step();
        bit conf = 1'b0;
        int old  = m_pos;
        if (m_idle) begin
            if (run_en) begin m_idle = 1'b0; m_pos = 0; end
        end else begin
            if (old == CYCLE - 1) begin
                m_src = 1'b0; m_iow = 1'b0; m_pos = 0;
                if (!run_en) m_idle = 1'b1;
            end else begin
                m_pos = old + 1;
            end
            if (old == 5 * ST - 1) begin
                conf  = (int'(src_req) + int'(iow_req) + int'(ior_req)) > 1;
                m_src = src_req;
                m_iow = iow_req && !src_req;
            end
        end
        exp_vec = model_expect(conf);
    endtask

    task automatic advance();
        @(posedge sysclk);
        model_step();
        #1;
    endtask

    // Subcycle the model will occupy after the next edge, assuming it keeps running.
    function automatic int next_sub();
        if (m_idle) return 0;
        return ((m_pos + 1) % CYCLE) / ST;
    endfunction

    task automatic test_reset();
        poc = 1'b1; run_en = 1'b0; src_req = 0; iow_req = 0; ior_req = 0;
        ip_addr = 0; sp_data = 0; acc_data = 0;
        #3;
        model_reset();
        for (int n = 0; n < 3; n++) begin
            checks++;
            if (dut_vec() !== exp_vec) begin
                failures++;
                $display("FAIL reset[%0d] got=%h exp=%h", n, dut_vec(), exp_vec);
            end
            run_en = 1'b1;
            @(posedge sysclk); #1;
        end
    endtask

    task automatic test_timing();
        int first_a1 = -1, first_sync = -1, sync_cnt = 0;
        poc = 1'b0; run_en = 1'b1;
        for (int n = 1; n <= CYCLE; n++) begin
            ip_addr = 4'($urandom); sp_data = 4'($urandom); acc_data = 4'($urandom);
            advance();
            checks++;
            if (dut_vec() !== exp_vec) begin
                failures++;
                $display("FAIL timing edge=%0d got=%h exp=%h", n, dut_vec(), exp_vec);
            end
            if (a12 === 1'b1 && first_a1 < 0) first_a1 = n;
            if (sync === 1'b1 && first_sync < 0) first_sync = n;
            if (sync === 1'b1) sync_cnt++;
        end
        checks++;
        if (first_a1 !== 1) begin
            failures++; $display("FAIL a1_latency got=%0d exp=1", first_a1);
        end
        checks++;
        if (first_sync !== 57) begin
            failures++; $display("FAIL x3_entry got=%0d exp=57", first_sync);
        end
        checks++;
        if (sync_cnt !== ST) begin
            failures++; $display("FAIL sync_width got=%0d exp=%0d", sync_cnt, ST);
        end
        $display("timing: a1=%0d x3=%0d sync_ticks=%0d", first_a1, first_sync, sync_cnt);
    endtask

    // One full cycle with directed data per subcycle and a fixed request mix.
    task automatic run_directed_cycle(input string name, input bit s, input bit w,
                                      input bit r, output int conf_cnt, output int x_drive);
        conf_cnt = 0; x_drive = 0;
        src_req = s; iow_req = w; ior_req = r; run_en = 1'b1;
        for (int n = 0; n < CYCLE; n++) begin
            int ns = next_sub();
            ip_addr  = (ns == 0) ? 4'hA : (ns == 1) ? 4'h5 : (ns == 2) ? 4'h3 : 4'($urandom);
            sp_data  = (ns == 6) ? 4'h7 : (ns == 7) ? 4'h2 : 4'($urandom);
            acc_data = (ns == 6) ? 4'hC : 4'($urandom);
            advance();
            checks++;
            if (dut_vec() !== exp_vec) begin
                failures++;
                $display("FAIL %s pos=%0d got=%h exp=%h", name, m_pos, dut_vec(), exp_vec);
            end
            if (bus_conflict === 1'b1) conf_cnt++;
            if (m_pos / ST >= 6 && data_dir === 1'b1) x_drive++;
        end
        src_req = 0; iow_req = 0; ior_req = 0;
    endtask

    task automatic test_addr();
        int c, x;
        run_directed_cycle("addr", 1'b0, 1'b0, 1'b0, c, x);
        checks++;
        if (x !== 0) begin failures++; $display("FAIL addr_xdrive got=%0d exp=0", x); end
    endtask

    task automatic test_src();
        int c, x;
        run_directed_cycle("src", 1'b1, 1'b0, 1'b0, c, x);
        checks++;
        if (c !== 0) begin failures++; $display("FAIL src_conflict got=%0d exp=0", c); end
        checks++;
        if (x !== 2 * ST) begin failures++; $display("FAIL src_xdrive got=%0d exp=%0d", x, 2 * ST); end
    endtask

    task automatic test_conflict();
        int c, x;
        run_directed_cycle("conflict", 1'b0, 1'b1, 1'b1, c, x);
        checks++;
        if (c !== 1) begin failures++; $display("FAIL conflict_pulses got=%0d exp=1", c); end
        checks++;
        if (x !== ST) begin failures++; $display("FAIL iow_xdrive got=%0d exp=%0d", x, ST); end
    endtask

    task automatic test_ior();
        int c, x;
        run_directed_cycle("ior", 1'b0, 1'b0, 1'b1, c, x);
        checks++;
        if (x !== 0) begin failures++; $display("FAIL ior_xdrive got=%0d exp=0", x); end
    endtask

    task automatic test_park();
        int idle_cnt = 0;
        bit reached = 1'b0;
        run_en = 1'b1;
        for (int n = 0; n < 2 * CYCLE && !reached; n++) begin
            advance();
            checks++;
            if (dut_vec() !== exp_vec) begin
                failures++; $display("FAIL park_run got=%h exp=%h", dut_vec(), exp_vec);
            end
            if (!m_idle && m_pos / ST == 3) reached = 1'b1;
        end
        run_en = 1'b0;
        for (int n = 0; n < 2 * CYCLE && idle_cnt < 10; n++) begin
            advance();
            checks++;
            if (dut_vec() !== exp_vec) begin
                failures++; $display("FAIL park_drain got=%h exp=%h", dut_vec(), exp_vec);
            end
            if (m_idle) idle_cnt++;
        end
        checks++;
        if (!reached || idle_cnt !== 10 || idle !== 1'b1 || clk1 !== 1'b0 || x32 !== 1'b0) begin
            failures++;
            $display("FAIL park_idle got=idle%b clk1%b cnt%0d exp=idle1 clk10 cnt10",
                     idle, clk1, idle_cnt);
        end
        run_en = 1'b1;
        advance();
        checks++;
        if (a12 !== 1'b1 || idle !== 1'b0) begin
            failures++; $display("FAIL park_restart got=a12:%b idle:%b exp=a12:1 idle:0", a12, idle);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 8 * CYCLE; n++) begin
            run_en   = ($urandom_range(0, 9) != 0);
            src_req  = ($urandom_range(0, 3) == 0);
            iow_req  = ($urandom_range(0, 2) == 0);
            ior_req  = ($urandom_range(0, 2) == 0);
            ip_addr  = 4'($urandom); sp_data = 4'($urandom); acc_data = 4'($urandom);
            advance();
            checks++;
            if (dut_vec() !== exp_vec) begin
                failures++;
                $display("FAIL random n=%0d got=%h exp=%h", n, dut_vec(), exp_vec);
            end
        end
        src_req = 0; iow_req = 0; ior_req = 0;
    endtask

    task automatic test_poc_mid();
        bit hit = 1'b0;
        run_en = 1'b1; iow_req = 1'b1; acc_data = 4'hC;
        for (int n = 0; n < 3 * CYCLE && !hit; n++) begin
            advance();
            if (!m_idle && m_pos / ST == 6) hit = 1'b1;
        end
        checks++;
        if (!hit || data_dir !== 1'b1 || data_out !== 4'hC) begin
            failures++; $display("FAIL poc_pre got=dir%b out%h exp=dir1 outc", data_dir, data_out);
        end
        #2 poc = 1'b1;
        #1;
        model_reset();
        checks++;
        if (dut_vec() !== exp_vec) begin
            failures++; $display("FAIL poc_async got=%h exp=%h", dut_vec(), exp_vec);
        end
        @(negedge sysclk);
        poc = 1'b0; iow_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_timing();
        test_addr();
        test_src();
        test_conflict();
        test_ior();
        test_park();
        test_random();
        test_poc_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
